// File: rtl/adder_pkg.sv
// Shared defaults, depth helper and segment result type for the segmented pipelined adder.
package adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG_W = 4;

    // Segment result: SEG_W sum bits with the segment carry on top.
    typedef logic [DEF_SEG_W:0] seg_sum_t;

    function automatic int stages(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG_W-bit ripple-carry segment built from one full adder per bit.
module adder_segment #(
    parameter int SEG_W = adder_pkg::DEF_SEG_W
) (
    input  logic [SEG_W-1:0] seg_a,
    input  logic [SEG_W-1:0] seg_b,
    input  logic             cin,
    output logic [SEG_W-1:0] seg_s,
    output logic             cout
);

    logic [SEG_W:0] carry;
    logic [SEG_W-1:0] prop;

    always_comb begin
        // NOTE: every variable written here gets a default first so no path can infer a latch.
        carry    = '0;
        prop     = '0;
        seg_s    = '0;
        carry[0] = cin;
        for (int i = 0; i < SEG_W; i++) begin
            prop[i]      = seg_a[i] ^ seg_b[i];
            seg_s[i]     = prop[i] ^ carry[i];
            carry[i+1]   = (seg_a[i] & seg_b[i]) | (carry[i] & prop[i]);
        end
        cout = carry[SEG_W];
    end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder resolving SEG_W bits per register stage, with a valid/ready
// handshake and a whole-pipeline stall whenever the output beat is not taken.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = stages(WIDTH, SEG_W);
    localparam int MSB    = WIDTH - 1;
    localparam logic [WIDTH-1:0] LOW_ONES = {WIDTH{1'b1}} >> (WIDTH - SEG_W);

    if (WIDTH % SEG_W != 0) begin : g_bad_width
        $error("pipelined_adder: WIDTH must be a multiple of SEG_W");
    end

    logic en;

    // Stage inputs: index k is what stage k consumes (stage 0 reads the ports).
    logic             v_src [STAGES];
    logic             c_src [STAGES];
    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];

    logic [SEG_W-1:0] seg_s  [STAGES];
    logic             seg_co [STAGES];
    logic [WIDTH-1:0] s_d    [STAGES];

    logic             valid_q [STAGES];
    logic             carry_q [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] s_q     [STAGES];

    logic ovf_d;
    logic ovf_q;

    assign out_valid = valid_q[STAGES-1];
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] SEG_MASK = LOW_ONES << (k * SEG_W);

        if (k == 0) begin : g_head
            assign v_src[k] = in_valid;
            assign c_src[k] = cin;
            assign a_src[k] = a;
            assign b_src[k] = b;
            assign s_src[k] = '0;
        end else begin : g_body
            assign v_src[k] = valid_q[k-1];
            assign c_src[k] = carry_q[k-1];
            assign a_src[k] = a_q[k-1];
            assign b_src[k] = b_q[k-1];
            assign s_src[k] = s_q[k-1];
        end

        adder_segment #(.SEG_W(SEG_W)) u_seg (
            .seg_a (a_src[k][k*SEG_W +: SEG_W]),
            .seg_b (b_src[k][k*SEG_W +: SEG_W]),
            .cin   (c_src[k]),
            .seg_s (seg_s[k]),
            .cout  (seg_co[k])
        );

        // Splice this stage's segment into the partial sum carried down the pipe.
        assign s_d[k] = (s_src[k] & ~SEG_MASK) | (WIDTH'(seg_s[k]) << (k * SEG_W));

        if (k == STAGES - 1) begin : g_last
            assign ovf_d = (a_src[k][MSB] == b_src[k][MSB]) &&
                           (seg_s[k][SEG_W-1] != a_src[k][MSB]);
        end

        // NOTE: the data flops are reset as well as the valid bits, so sum/cout read zero after reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                s_q[k]     <= '0;
            end else if (en) begin
                valid_q[k] <= v_src[k];
                carry_q[k] <= seg_co[k];
                a_q[k]     <= a_src[k];
                b_q[k]     <= b_src[k];
                s_q[k]     <= s_d[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_d;
        end
    end

    assign sum  = s_q[STAGES-1];
    assign cout = carry_q[STAGES-1];
    assign ovf  = ovf_q;

endmodule
